sd_cmd_serializer: RTL and testbench

SD command-line engine that sits directly downstream of the wishbone slave and register file. On `new_command` it captures the command and argument register values and serializes a 48-bit command token, CRC7 included, onto the CMD line. It then receives and checks the card's 48- or 136-bit response and returns `cmd_done` to the wishbone slave's `cmd_done_i`, along with the response word and error flags for the register file.

---
 rtl/sd_cmd_serializer_if.sv | 21 ++
 rtl/sd_cmd_serializer.sv | 159 +++++++++++++++
 tb/tb_sd_cmd_serializer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sd_cmd_serializer_if.sv
// Command/response handshake between the register-file side and the SD CMD-line engine.
// The master drives the request fields; the slave returns status and the response.
interface sd_cmd_serializer_if;
    logic         new_command;
    logic [15:0]  command;
    logic [31:0]  argument;
    logic         busy;
    logic         cmd_done;
    logic [127:0] response;
    logic [3:0]   error_status;

    modport master (
        output new_command, command, argument,
        input  busy, cmd_done, response, error_status
    );

    modport slave (
        input  new_command, command, argument,
        output busy, cmd_done, response, error_status
    );
endinterface

// File: rtl/sd_cmd_serializer.sv
// SD CMD-line engine: serializes a 48-bit command token with CRC7, then receives and
// checks a 48- or 136-bit response and reports it with a one-cycle done pulse.
module sd_cmd_serializer #(
    parameter int TIMEOUT = 64
) (
    input  logic                clock,
    input  logic                reset,
    sd_cmd_serializer_if.slave  host,
    input  logic                cmd_in,
    output logic                cmd_out,
    output logic                cmd_oe
);
    typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECV, DONE} state_t;

    localparam int                WAIT_W    = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t              state_reg;
    logic [47:0]         token_reg;
    logic [1:0]          rtype_reg;
    logic [5:0]          index_reg;
    logic [7:0]          bit_cnt_reg;
    logic [WAIT_W-1:0]   wait_cnt_reg;
    logic [126:0]        shift_reg;
    logic                busy_reg;
    logic                cmd_done_reg;
    logic                cmd_out_reg;
    logic                cmd_oe_reg;
    logic [127:0]        response_reg;
    logic [3:0]          error_reg;

    // CRC7 (x^7+x^3+1, zero init). Leading zeros leave a zero-initialized CRC unchanged,
    // so the 40-bit fields are zero-extended and share this single 120-bit routine.
    function automatic logic [6:0] crc7(input logic [119:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = '0;
        for (int i = 119; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return crc;
    endfunction

    logic [39:0]  cmd_body;
    logic [127:0] shift_next;
    logic [7:0]   resp_len;
    logic         last_bit;
    logic [6:0]   crc_short;
    logic [6:0]   crc_long;
    logic [3:0]   err48;
    logic [3:0]   err136;

    assign cmd_body   = {2'b01, host.command[13:8], host.argument};
    assign shift_next = {shift_reg, cmd_in};
    assign resp_len   = (rtype_reg == 2'b01) ? 8'd136 : 8'd48;
    assign last_bit   = (bit_cnt_reg == resp_len - 8'd1);
    assign crc_short  = crc7({80'b0, shift_next[47:8]});
    assign crc_long   = crc7(shift_next[127:8]);

    // {index_err, end_bit_err, crc_err, timeout_err}
    assign err48  = {shift_next[45:40] != index_reg,
                     shift_next[46] | ~shift_next[0],
                     crc_short != shift_next[7:1],
                     1'b0};
    assign err136 = {1'b0, ~shift_next[0], crc_long != shift_next[7:1], 1'b0};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            token_reg    <= '0;
            rtype_reg    <= '0;
            index_reg    <= '0;
            bit_cnt_reg  <= '0;
            wait_cnt_reg <= '0;
            shift_reg    <= '0;
            busy_reg     <= 1'b0;
            cmd_done_reg <= 1'b0;
            cmd_out_reg  <= 1'b1;
            cmd_oe_reg   <= 1'b0;
            response_reg <= '0;
            error_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (host.new_command) begin
                        token_reg   <= {cmd_body, crc7({80'b0, cmd_body}), 1'b1};
                        rtype_reg   <= host.command[1:0];
                        index_reg   <= host.command[13:8];
                        error_reg   <= '0;
                        bit_cnt_reg <= '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= SEND;
                    end
                end
                SEND: begin
                    if (bit_cnt_reg == 8'd48) begin
                        cmd_oe_reg   <= 1'b0;
                        cmd_out_reg  <= 1'b1;
                        wait_cnt_reg <= '0;
                        if (rtype_reg == 2'b00) begin
                            cmd_done_reg <= 1'b1;
                            state_reg    <= DONE;
                        end else begin
                            state_reg <= WAIT_RESP;
                        end
                    end else begin
                        cmd_oe_reg  <= 1'b1;
                        cmd_out_reg <= token_reg[47];
                        token_reg   <= {token_reg[46:0], 1'b0};
                        bit_cnt_reg <= bit_cnt_reg + 8'd1;
                    end
                end
                WAIT_RESP: begin
                    if (!cmd_in) begin
                        // The start bit itself is a zero, so a cleared shifter already holds it.
                        shift_reg   <= '0;
                        bit_cnt_reg <= 8'd1;
                        state_reg   <= RECV;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        error_reg[0] <= 1'b1;
                        cmd_done_reg <= 1'b1;
                        state_reg    <= DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
                RECV: begin
                    shift_reg   <= shift_next[126:0];
                    bit_cnt_reg <= bit_cnt_reg + 8'd1;
                    if (last_bit) begin
                        if (rtype_reg == 2'b01) begin
                            response_reg <= {8'b0, shift_next[127:8]};
                            error_reg    <= err136;
                        end else begin
                            response_reg <= {96'b0, shift_next[39:8]};
                            error_reg    <= err48;
                        end
                        cmd_done_reg <= 1'b1;
                        state_reg    <= DONE;
                    end
                end
                DONE: begin
                    cmd_done_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cmd_out           = cmd_out_reg;
    assign cmd_oe            = cmd_oe_reg;
    assign host.busy         = busy_reg;
    assign host.cmd_done     = cmd_done_reg;
    assign host.response     = response_reg;
    assign host.error_status = error_reg;
endmodule

// File: tb/tb_sd_cmd_serializer.sv
// Self-checking bench for sd_cmd_serializer: per-cycle expected waveform built from
// the protocol's timing rules, plus literal checks of tokens, responses and error flags.
module tb_sd_cmd_serializer;
    localparam int TIMEOUT = 64;
    localparam int NCYC    = 20000;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic cmd_in = 1'b1;
    logic cmd_out;
    logic cmd_oe;
    int   cyc    = 0;
    int   tests  = 0;
    int   fails  = 0;

    sd_cmd_serializer_if host();

    sd_cmd_serializer #(.TIMEOUT(TIMEOUT)) dut (
        .clock   (clock),
        .reset   (reset),
        .host    (host),
        .cmd_in  (cmd_in),
        .cmd_out (cmd_out),
        .cmd_oe  (cmd_oe)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Expected outputs after edge k, and stimulus to be sampled at edge k.
    bit exp_oe   [NCYC];
    bit exp_out  [NCYC];
    bit exp_busy [NCYC];
    bit exp_done [NCYC];
    bit cin_sched[NCYC];
    bit nc_sched [NCYC];

    logic [127:0] exp_resp;
    logic [3:0]   exp_err;
    logic [127:0] last_resp = '0;
    logic [47:0]  ser = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // Remainder of msg(x)*x^7 modulo x^7+x^3+1, by plain polynomial long division.
    function automatic logic [6:0] crc7_div(input logic [119:0] msg);
        logic [126:0] r;
        r = {msg, 7'b0};
        for (int i = 126; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [47:0] frame48(input logic tbit, input logic [5:0] idx,
                                            input logic [31:0] payload);
        logic [39:0] body;
        body = {1'b0, tbit, idx, payload};
        return {body, crc7_div({80'b0, body}), 1'b1};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
        cmd_in           = cin_sched[cyc + 1];
        host.new_command = nc_sched[cyc + 1];
    endtask

    // kind: 0 good, 1 CRC bit flipped, 2 wrong index, 3 end bit 0, 4 transmission bit 1,
    // 5 card silent. abort_bit >= 0 asserts reset while that token bit is on the line.
    task automatic run_cmd(input logic [15:0] cmd, input logic [31:0] arg, input int kind,
                           input int delay, input logic [119:0] payload, input int abort_bit);
        int          n, s, d, len, fl;
        logic [47:0] tok;
        logic [135:0] r;
        logic        r2;
        n  = cyc + 2;
        r2 = (cmd[1:0] == 2'b01);
        host.command  = cmd;
        host.argument = arg;
        nc_sched[n] = 1'b1;
        tok = frame48(1'b1, cmd[13:8], arg);
        for (int k = 1; k <= 48; k++) begin
            exp_oe[n + k]  = 1'b1;
            exp_out[n + k] = tok[48 - k];
        end
        ser = '0;
        r   = '0;
        s   = 0;
        if (cmd[1:0] == 2'b00) begin
            d = n + 49;
            exp_err = 4'b0000;
        end else if (kind == 5) begin
            d = n + 49 + TIMEOUT;
            exp_err = 4'b0001;
        end else begin
            if (r2) begin
                len = 136;
                r = {2'b00, 6'h3F, payload, crc7_div(payload), 1'b1};
                last_resp = {8'b0, payload};
            end else begin
                len = 48;
                r[47:0] = frame48(kind == 4, (kind == 2) ? cmd[13:8] + 6'd1 : cmd[13:8],
                                  payload[31:0]);
                last_resp = {96'b0, payload[31:0]};
            end
            if (kind == 1) begin
                fl = $urandom_range(1, 7);
                r[fl] = ~r[fl];
            end
            if (kind == 3) r[0] = 1'b0;
            s = n + 50 + delay;
            for (int j = 0; j < len; j++) cin_sched[s + j] = r[len - 1 - j];
            d = s + len - 1;
            exp_err = (kind == 1) ? 4'b0010 :
                      (kind == 2 && !r2) ? 4'b1000 :
                      (kind == 3 || (kind == 4 && !r2)) ? 4'b0100 : 4'b0000;
            nc_sched[$urandom_range(s + 1, d)] = 1'b1;
        end
        exp_resp = last_resp;
        for (int k = n; k <= d; k++) exp_busy[k] = 1'b1;
        exp_done[d] = 1'b1;
        for (int k = 0; k < 3; k++) nc_sched[$urandom_range(n + 1, d + 1)] = 1'b1;

        while (cyc < d + 2) begin
            step();
            if (cyc >= n) begin
                host.command  = 16'($urandom);
                host.argument = $urandom;
            end
            if (cyc == n + 1) chk("error_cleared", 128'(host.error_status), '0);
            if (abort_bit >= 0 && cyc == n + 1 + abort_bit) begin
                reset = 1'b0;
                for (int k = cyc; k <= d + 2; k++) begin
                    exp_oe[k] = 1'b0; exp_out[k] = 1'b1; exp_busy[k] = 1'b0; exp_done[k] = 1'b0;
                end
                for (int k = cyc + 1; k <= d + 2; k++) begin
                    cin_sched[k] = 1'b1; nc_sched[k] = 1'b0;
                end
                #1;
                chk("abort_oe", 128'(cmd_oe), '0);
                chk("abort_out", 128'(cmd_out), 128'(1'b1));
                repeat (2) step();
                chk("abort_resp", host.response, '0);
                chk("abort_err", 128'(host.error_status), '0);
                reset = 1'b1;
                last_resp = '0;
                break;
            end
        end
        $display("[TB] txn cmd=%h arg=%h kind=%0d start=%0d end=%0d resp=%h err=%b",
                 cmd, arg, kind, n, d, host.response, host.error_status);
    endtask

    // Per-cycle compare against the expected waveform.
    initial begin
        forever begin
            @(negedge clock);
            if (cyc < NCYC) begin
                if (cmd_oe) ser = {ser[46:0], cmd_out};
                chk("cmd_oe", 128'(cmd_oe), 128'(exp_oe[cyc]));
                chk("cmd_out", 128'(cmd_out), 128'(exp_out[cyc]));
                chk("busy", 128'(host.busy), 128'(exp_busy[cyc]));
                chk("cmd_done", 128'(host.cmd_done), 128'(exp_done[cyc]));
                if (exp_done[cyc]) begin
                    chk("response", host.response, exp_resp);
                    chk("error_status", 128'(host.error_status), 128'(exp_err));
                end
            end
        end
    end

    initial begin
        logic [119:0] pay;
        logic [15:0]  c;
        int           kind;
        for (int k = 0; k < NCYC; k++) begin
            exp_oe[k] = 1'b0; exp_out[k] = 1'b1; exp_busy[k] = 1'b0; exp_done[k] = 1'b0;
            cin_sched[k] = 1'b1; nc_sched[k] = 1'b0;
        end
        host.new_command = 1'b0;
        host.command     = '0;
        host.argument    = '0;
        #2 reset = 1'b0;
        repeat (3) step();
        chk("reset_resp", host.response, '0);
        chk("reset_err", 128'(host.error_status), '0);
        reset = 1'b1;
        step();

        run_cmd(16'h0000, 32'h0, 0, 0, '0, -1);
        chk("cmd0_token", 128'(ser), 128'(48'h400000000095));
        chk("cmd0_err", 128'(host.error_status), '0);

        run_cmd(16'h081A, 32'h000001AA, 0, 3, 120'h1AA, -1);
        chk("cmd8_token", 128'(ser), 128'(48'h48000001AA87));
        chk("cmd8_resp", host.response, 128'h1AA);
        chk("cmd8_err", 128'(host.error_status), '0);

        run_cmd(16'h081A, 32'h000001AA, 1, 0, 120'h1AA, -1);
        chk("crc_flip_err", 128'(host.error_status), 128'(4'b0010));
        run_cmd(16'h081A, 32'h000001AA, 2, 5, 120'h1AA, -1);
        chk("index_err", 128'(host.error_status), 128'(4'b1000));
        run_cmd(16'h081A, 32'h000001AA, 3, 1, 120'h1AA, -1);
        chk("end_bit_err", 128'(host.error_status), 128'(4'b0100));

        run_cmd(16'h081A, 32'h000001AA, 5, 0, '0, -1);
        chk("timeout_err", 128'(host.error_status), 128'(4'b0001));
        chk("timeout_resp_kept", host.response, 128'h1AA);

        run_cmd(16'h0209, 32'h0, 0, 7, 120'h0123456789ABCDEF0123456789ABEF, -1);
        chk("r2_resp", host.response, 128'h0123456789ABCDEF0123456789ABEF);
        chk("r2_err", 128'(host.error_status), '0);

        run_cmd(16'h081A, 32'h000001AA, 0, 0, 120'h1AA, 20);
        run_cmd(16'h0000, 32'h0, 0, 0, '0, -1);
        chk("post_reset_token", 128'(ser), 128'(48'h400000000095));
        chk("post_reset_err", 128'(host.error_status), '0);

        for (int t = 0; t < 25; t++) begin
            c    = 16'($urandom);
            kind = (c[1:0] == 2'b00) ? 0 : int'($urandom_range(0, 5));
            pay  = {24'($urandom), $urandom, $urandom, $urandom};
            run_cmd(c, $urandom, kind, int'($urandom_range(0, TIMEOUT - 1)), pay, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
